mem_responder: RTL and testbench

//  Memory-side responder for the CPU's data/instruction memory port. Accepts one request at a

---
 rtl/mem_pkg.sv | 32 +++
 rtl/mem_responder_if.sv | 26 ++
 rtl/mem_lane_merge.sv | 46 ++++
 rtl/mem_responder.sv | 167 ++++++++++++++++
 tb/tb_mem_responder.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared size codes, FSM encoding and lane-mask helper for mem_responder
// Purpose: common definitions imported by the memory responder and its lane-merge helper.
// Ports: none (package).
package mem_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MERGE  = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // One bit per byte lane touched by an access of the given size at byte offset off.
  // Assumes the access is aligned; misaligned requests never reach the datapath.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    m = 4'h0;
    case (size)
      SZ_WORD: m = 4'hF;
      SZ_HALF: m = off[1] ? 4'hC : 4'h3;
      SZ_BYTE: m = 4'b0001 << off;
      default: m = 4'h0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response bus between CPU memory port and mem_responder
// Purpose: bundles the valid/ready request channel and the single-cycle response strobe.
// Signals: req_valid/req_ready handshake; req_we, req_size, req_addr, req_wdata request fields;
//          rsp_valid strobe with rsp_err and rsp_rdata.
// Modports: master = requester (CPU side), slave = responder (memory side).
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/mem_lane_merge.sv
// rtl/mem_lane_merge.sv - combinational byte-lane merge (stores) and extract (loads)
// Purpose: little-endian lane handling for word/half/byte accesses.
// Ports: i_word    current 32-bit storage word
//        i_off     byte offset addr[1:0]
//        i_size    access size code
//        i_item    store item in the low bits
//        o_merged  i_word with i_item substituted in the addressed lane(s)
//        o_extract addressed item, zero-extended
module mem_lane_merge
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_item,
  output logic [31:0] o_merged,
  output logic [31:0] o_extract
);

  logic [4:0]  w_shamt;
  logic [3:0]  w_mask;
  logic [31:0] w_bitmask;
  logic [31:0] w_item_sh;
  logic [31:0] w_word_sh;

  assign w_shamt   = {i_off, 3'b000};
  assign w_mask    = lane_mask(i_size, i_off);
  assign w_bitmask = {{8{w_mask[3]}}, {8{w_mask[2]}}, {8{w_mask[1]}}, {8{w_mask[0]}}};

  // Item moves up into its lane; only the masked lanes of it survive.
  assign w_item_sh = i_item << w_shamt;
  assign o_merged  = (i_word & ~w_bitmask) | (w_item_sh & w_bitmask);

  // Addressed lane moves down to bit 0 and is trimmed to the access width.
  assign w_word_sh = i_word >> w_shamt;

  always_comb begin
    o_extract = w_word_sh;
    case (i_size)
      SZ_HALF: o_extract = w_word_sh & 32'h0000_FFFF;
      SZ_BYTE: o_extract = w_word_sh & 32'h0000_00FF;
      default: o_extract = w_word_sh;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - memory-side responder with wait states and sub-word read-modify-write
// Purpose: owns the storage array, accepts one request at a time and answers with a one-cycle
//          response; sub-word stores run as read-merge-write; bad requests are rejected early.
// Ports: clk    single clock, rising edge
//        reset  asynchronous active-low reset
//        bus    mem_responder_if.slave (request handshake + response strobe)
// Parameters: DEPTH_WORDS storage words, WAIT extra cycles per array touch (0..15).
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT        = 1
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);

  localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] BYTE_CAP = 33'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WAIT_CNT = 4'(WAIT);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic [AW-1:0] r_idx;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_req_err;
  logic        w_ready;
  logic        w_accept;
  logic        w_cnt_dec;
  logic        w_cap_load;
  logic        w_cap_buf;
  logic        w_mem_we;
  logic [31:0] w_mem_wdata;
  logic [31:0] w_mem_rd;
  logic [31:0] w_merge_word;
  logic [31:0] w_merged;
  logic [31:0] w_extract;

  // Range check uses the full 32-bit address so high garbage bits cannot alias into the array.
  assign w_req_err = (bus.req_size == SZ_RSVD)
                   | ((bus.req_size == SZ_HALF) & bus.req_addr[0])
                   | ((bus.req_size == SZ_WORD) & (bus.req_addr[1:0] != 2'b00))
                   | ({1'b0, bus.req_addr} >= BYTE_CAP);

  assign w_mem_rd     = r_mem[r_idx];
  // MERGE works from the snapshot taken in ACCESS; loads extract straight from the array.
  assign w_merge_word = (r_state == ST_MERGE) ? r_buf : w_mem_rd;

  mem_lane_merge u_lane_merge (
    .i_word    (w_merge_word),
    .i_off     (r_off),
    .i_size    (r_size),
    .i_item    (r_wdata),
    .o_merged  (w_merged),
    .o_extract (w_extract)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_accept    = 1'b0;
    w_cnt_dec   = 1'b0;
    w_cap_load  = 1'b0;
    w_cap_buf   = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_wdata = r_wdata;
    unique case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (bus.req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = w_req_err ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (r_cnt != 4'd0) begin
          w_cnt_dec = 1'b1;
        end else if (!r_we) begin
          w_cap_load  = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (r_size == SZ_WORD) begin
          w_mem_we    = 1'b1;
          w_state_nxt = ST_RESP;
        end else begin
          w_cap_buf   = 1'b1;
          w_state_nxt = ST_MERGE;
        end
      end
      ST_MERGE: begin
        w_mem_we    = 1'b1;
        w_mem_wdata = w_merged;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_size  <= SZ_WORD;
      r_off   <= 2'b00;
      r_idx   <= '0;
      r_wdata <= 32'h0;
      r_buf   <= 32'h0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_size  <= bus.req_size;
        r_off   <= bus.req_addr[1:0];
        r_idx   <= bus.req_addr[AW+1:2];
        r_wdata <= bus.req_wdata;
        r_err   <= w_req_err;
        r_cnt   <= WAIT_CNT;
        if (w_req_err) begin
          r_rdata <= 32'h0;
        end
      end
      if (w_cnt_dec) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_cap_load) begin
        r_rdata <= w_extract;
      end
      if (w_cap_buf) begin
        r_buf <= w_mem_rd;
      end
    end
  end

  // Storage keeps its contents across reset; writes are only issued from ACCESS/MERGE,
  // which reset forces out of, so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_idx] <= w_mem_wdata;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = (r_state == ST_RESP);
  assign bus.rsp_err   = r_err & (r_state == ST_RESP);
  assign bus.rsp_rdata = r_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder
module tb_mem_responder;

  localparam int DEPTH = 64;
  localparam int WAITC = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_responder_if bus();

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT(WAITC)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mm [DEPTH];
  int          busy_until   = -1;
  int          exp_resp_cyc = -1;
  bit          pend         = 1'b0;
  bit          exp_err      = 1'b0;
  bit          exp_has_rd   = 1'b0;
  logic [31:0] exp_rd       = 32'h0;
  logic [31:0] hold         = 32'h0;
  bit          chk_en       = 1'b0;

  int          last_e0        = 0;
  int          last_rsp_cyc   = 0;
  logic        last_rsp_err   = 1'b0;
  logic [31:0] last_rsp_rdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin : cmp
    bit is_resp;
    if (chk_en) begin
      is_resp = pend && (cyc == exp_resp_cyc);
      check("rsp_valid", 32'(bus.rsp_valid), 32'(is_resp));
      check("req_ready", 32'(bus.req_ready), 32'(cyc > busy_until));
      if (is_resp) begin
        check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
        if (exp_has_rd) hold = exp_rd;
        pend           = 1'b0;
        last_rsp_cyc   = cyc;
        last_rsp_err   = bus.rsp_err;
        last_rsp_rdata = bus.rsp_rdata;
      end
      check("rsp_rdata", bus.rsp_rdata, hold);
    end
  end

  function automatic bit model_err(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'b11) || (size == 2'b01 && (addr % 2) != 0) ||
           (size == 2'b00 && (addr % 4) != 0) || (addr >= 32'(DEPTH * 4));
  endfunction

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while (cyc <= busy_until && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle: got timeout expected idle");
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit keep);
    int lat, nb, k, idx;
    logic [31:0] w;
    bit e;
    wait_idle();
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = size;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    #1;
    last_e0 = cyc;
    e   = model_err(size, addr);
    nb  = (size == 2'b00) ? 4 : (size == 2'b01) ? 2 : 1;
    k   = int'(addr[1:0]);
    idx = int'(addr >> 2);
    if (e) lat = 1;
    else if (!we || size == 2'b00) lat = WAITC + 2;
    else lat = WAITC + 3;
    exp_err    = e;
    exp_has_rd = e || !we;
    exp_rd     = 32'h0;
    if (!e) begin
      w = mm[idx];
      if (!we) begin
        for (int i = 0; i < nb; i++) exp_rd[8*i +: 8] = w[8*(k+i) +: 8];
      end else begin
        for (int i = 0; i < nb; i++) w[8*(k+i) +: 8] = wdata[8*i +: 8];
        mm[idx] = w;
      end
    end
    exp_resp_cyc = cyc + lat - 1;
    busy_until   = exp_resp_cyc;
    pend         = 1'b1;
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic check_last(input string name, input int lat, input logic err, input logic [31:0] rd);
    wait_idle();
    check({name, "_lat"}, 32'(last_rsp_cyc - last_e0 + 1), 32'(lat));
    check({name, "_err"}, 32'(last_rsp_err), 32'(err));
    check({name, "_rdata"}, last_rsp_rdata, rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b00;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    for (int i = 0; i < DEPTH; i++) mm[i] = 32'h0;

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("reset_rsp_err", 32'(bus.rsp_err), 32'h0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Reset aborts an in-flight word store
    do_req(1'b1, 2'b00, 32'h10, 32'h5566_7788, 1'b0);
    wait_idle();
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b00;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'h1122_3344;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk_en        = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("abort_rsp_err", 32'(bus.rsp_err), 32'h0);
    check("abort_rsp_rdata", bus.rsp_rdata, 32'h0);
    hold       = 32'h0;
    pend       = 1'b0;
    busy_until = cyc;
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    do_req(1'b0, 2'b00, 32'h10, 32'h0, 1'b0);
    check_last("abort_reload", 3, 1'b0, 32'h5566_7788);

    // Word store / load
    do_req(1'b1, 2'b00, 32'h08, 32'hDEAD_BEEF, 1'b0);
    check_last("st_word", 3, 1'b0, 32'h5566_7788);
    do_req(1'b0, 2'b00, 32'h08, 32'h0, 1'b0);
    check_last("ld_word", 3, 1'b0, 32'hDEAD_BEEF);

    // Byte store
    do_req(1'b1, 2'b10, 32'h09, 32'hFFFF_FFAA, 1'b0);
    check_last("st_byte", 4, 1'b0, 32'hDEAD_BEEF);
    do_req(1'b0, 2'b00, 32'h08, 32'h0, 1'b0);
    check_last("ld_word_b", 3, 1'b0, 32'hDEAD_AAEF);
    do_req(1'b0, 2'b10, 32'h09, 32'h0, 1'b0);
    check_last("ld_byte", 3, 1'b0, 32'h0000_00AA);

    // Half store
    do_req(1'b1, 2'b01, 32'h0A, 32'h0000_1234, 1'b0);
    check_last("st_half", 4, 1'b0, 32'h0000_00AA);
    do_req(1'b0, 2'b00, 32'h08, 32'h0, 1'b0);
    check_last("ld_word_h", 3, 1'b0, 32'h1234_AAEF);
    do_req(1'b0, 2'b01, 32'h0A, 32'h0, 1'b0);
    check_last("ld_half", 3, 1'b0, 32'h0000_1234);
    check("model_pin_w2", mm[2], 32'h1234_AAEF);

    // Rejected accesses
    do_req(1'b0, 2'b00, 32'h06, 32'h0, 1'b0);
    check_last("err_mis_word", 1, 1'b1, 32'h0);
    do_req(1'b0, 2'b00, 32'h08, 32'h0, 1'b0);
    do_req(1'b0, 2'b01, 32'h03, 32'h0, 1'b0);
    check_last("err_mis_half", 1, 1'b1, 32'h0);
    do_req(1'b0, 2'b11, 32'h00, 32'h0, 1'b0);
    check_last("err_rsvd", 1, 1'b1, 32'h0);
    do_req(1'b0, 2'b00, 32'h100, 32'h0, 1'b0);
    check_last("err_range", 1, 1'b1, 32'h0);
    do_req(1'b1, 2'b00, 32'hFFFF_FF08, 32'h0BAD_0BAD, 1'b0);
    check_last("err_range_hi", 1, 1'b1, 32'h0);
    do_req(1'b1, 2'b11, 32'h08, 32'h0BAD_0BAD, 1'b0);
    do_req(1'b1, 2'b01, 32'h09, 32'h0BAD_0BAD, 1'b0);
    do_req(1'b0, 2'b00, 32'h08, 32'h0, 1'b0);
    check_last("err_untouched", 3, 1'b0, 32'h1234_AAEF);

    // Top of the array
    do_req(1'b1, 2'b00, 32'hFC, 32'h0102_0304, 1'b0);
    do_req(1'b0, 2'b10, 32'hFF, 32'h0, 1'b0);
    check_last("ld_top_byte", 3, 1'b0, 32'h0000_0001);

    // req_valid held high across back-to-back requests
    do_req(1'b1, 2'b10, 32'hFF, 32'h0000_005A, 1'b1);
    do_req(1'b0, 2'b10, 32'hFF, 32'h0, 1'b1);
    do_req(1'b0, 2'b00, 32'hFC, 32'h0, 1'b1);
    do_req(1'b1, 2'b00, 32'h20, 32'hCAFE_F00D, 1'b1);
    do_req(1'b0, 2'b01, 32'h07, 32'h0, 1'b1);
    do_req(1'b0, 2'b00, 32'h20, 32'h0, 1'b0);
    check_last("held_ld", 3, 1'b0, 32'hCAFE_F00D);
    check("model_pin_top", mm[63], 32'h5A02_0304);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
